// File: rtl/joy_pkg.sv
// DB15 joystick link constants: FSM state type, player-word bit positions, frame length.
// Pure declarations; no timing or flow control.
package joy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } joy_state_t;

  localparam int JOY_WORD_BITS   = 12;
  localparam int DB15_FRAME_BITS = 2 * JOY_WORD_BITS;

  localparam int JOY_BIT_R  = 0;
  localparam int JOY_BIT_L  = 1;
  localparam int JOY_BIT_D  = 2;
  localparam int JOY_BIT_U  = 3;
  localparam int JOY_BIT_A  = 4;
  localparam int JOY_BIT_B  = 5;
  localparam int JOY_BIT_C  = 6;
  localparam int JOY_BIT_D2 = 7;
  localparam int JOY_BIT_E  = 8;
  localparam int JOY_BIT_F  = 9;
  localparam int JOY_BIT_S  = 10;
  localparam int JOY_BIT_LS = 11;

  // Pins are active low, so pressed buttons go out as 0; P1 R ends up in bit 0.
  function automatic logic [DB15_FRAME_BITS-1:0] frame_word(
    input logic [JOY_WORD_BITS-1:0] p1,
    input logic [JOY_WORD_BITS-1:0] p2
  );
    return {~p2, ~p1};
  endfunction

endpackage

// File: rtl/joy_sync_edge.sv
// 2-FF pin synchronizer with level/rise/fall outputs; edge flags are valid 2 clk after the pin
// (2+FILT_LEN with JOY_DB15_TX_FILTER_EN, which adds a FILT_LEN-sample glitch filter). No backpressure.
module joy_sync_edge #(
  parameter int FILT_LEN = 4,
  parameter bit RST_VAL  = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

`ifdef JOY_DB15_TX_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_lvl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= w_lvl;
    end
  end

  generate
    if (FILT_ON && (FILT_LEN > 0)) begin : g_filt
      localparam int CW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
      localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

      logic [CW-1:0] r_cnt;
      logic          r_filt;

      // Counts consecutive samples that disagree with the filtered level.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cnt  <= '0;
          r_filt <= RST_VAL;
        end else if (r_sync == r_filt) begin
          r_cnt  <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_cnt  <= '0;
          r_filt <= r_sync;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end

      assign w_lvl = r_filt;
    end else begin : g_raw
      assign w_lvl = r_sync;
    end
  endgenerate

  assign o_lvl  = w_lvl;
  assign o_rise = w_lvl & ~r_prev;
  assign o_fall = ~w_lvl & r_prev;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 adapter emulation: snapshots two player words on joy_load low and shifts them out on joy_clk rises;
// pin-to-joy_data latency 3 clk (3+FILT_LEN with JOY_DB15_TX_FILTER_EN). No backpressure; extra clocks flag overrun.
module joy_db15_tx
  import joy_pkg::*;
#(
  parameter int FRAME_BITS = DB15_FRAME_BITS,
  parameter int FILT_LEN   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [JOY_WORD_BITS-1:0] joystick1,
  input  logic [JOY_WORD_BITS-1:0] joystick2,
  input  logic                     joy_load,
  input  logic                     joy_clk,
  output logic                     joy_data,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     overrun
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

  logic w_load_lvl, w_load_rise, w_load_fall;
  logic w_clk_lvl, w_clk_rise, w_clk_fall;
  logic w_unused;

  joy_state_t r_state;
  joy_state_t w_state_nxt;

  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_frame;
  logic [CW-1:0]         r_cnt;
  logic                  r_overrun;
  logic                  r_frame_done;

  // Load idles high so a released pin never looks like a fresh load after reset.
  joy_sync_edge #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b1)) u_sync_load (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_pin   (joy_load),
    .o_lvl   (w_load_lvl),
    .o_rise  (w_load_rise),
    .o_fall  (w_load_fall)
  );

  joy_sync_edge #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b0)) u_sync_clk (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_pin   (joy_clk),
    .o_lvl   (w_clk_lvl),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  assign w_unused = &{1'b0, w_load_fall, w_clk_lvl, w_clk_fall};
  assign w_frame  = FRAME_BITS'(frame_word(joystick1, joystick2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A low load level outranks everything, including a clk edge in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_load_lvl) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:  if (w_load_rise) w_state_nxt = ST_SHIFT;
        ST_SHIFT: if (w_clk_rise && (r_cnt == LAST_BIT)) w_state_nxt = ST_DONE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    joy_data = 1'b1;
    busy     = 1'b0;
    case (r_state)
      ST_LOAD:  joy_data = r_shift[0];
      ST_SHIFT: begin
        joy_data = r_shift[0];
        busy     = 1'b1;
      end
      default: begin
        joy_data = 1'b1;
        busy     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '1;
      r_cnt        <= '0;
      r_overrun    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (!w_load_lvl) begin
        r_shift   <= w_frame;
        r_cnt     <= '0;
        r_overrun <= 1'b0;
      end else if (w_clk_rise) begin
        if (r_state == ST_SHIFT) begin
          r_shift      <= {1'b1, r_shift[FRAME_BITS-1:1]};
          r_cnt        <= r_cnt + 1'b1;
          r_frame_done <= (r_cnt == LAST_BIT);
        end else if (r_state == ST_DONE) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: drives the load/clk pins slowly and scoreboards the serial stream.
module tb_joy_db15_tx;

`ifdef JOY_DB15_TX_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = 12;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] joystick1 = '0;
  logic [11:0] joystick2 = '0;
  logic        joy_load = 1'b1;
  logic        joy_clk = 1'b0;
  logic        joy_data, frame_done, busy, overrun;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  joy_db15_tx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_load   (joy_load),
    .joy_clk    (joy_clk),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_pulse(input logic [11:0] p1, input logic [11:0] p2);
    joystick1 = p1;
    joystick2 = p2;
    joy_load = 1'b0;
    cyc(HOLD);
    joy_load = 1'b1;
    cyc(HOLD);
  endtask

  task automatic pulse_clk(input int hi);
    joy_clk = 1'b1;
    cyc(hi);
    joy_clk = 1'b0;
    cyc(HOLD);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc(3);
    checks++; if (joy_data !== 1'b1) begin errors++; $display("FAIL reset_data got %b want 1", joy_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    reset_n = 1'b1;
    cyc(HOLD);
    checks++; if (joy_data !== 1'b1) begin errors++; $display("FAIL idle_data got %b want 1", joy_data); end
  endtask

  task automatic test_latency();
    load_pulse(12'h001, 12'h000);
    checks++; if (joy_data !== 1'b0) begin errors++; $display("FAIL lat_bit0 got %b want 0", joy_data); end
    joy_clk = 1'b1;
    cyc(LAT - 1);
    checks++; if (joy_data !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", joy_data); end
    cyc(1);
    checks++; if (joy_data !== 1'b1) begin errors++; $display("FAIL lat_edge got %b want 1", joy_data); end
    joy_clk = 1'b0;
    cyc(HOLD);
  endtask

  task automatic test_frame(input logic [11:0] p1, input logic [11:0] p2);
    logic [23:0] w;
    logic [23:0] cap;
    logic        e;
    int          d0;
    w = {~p2, ~p1};
    cap = '0;
    d0 = done_cnt;
    load_pulse(p1, p2);
    exp_q.push_back(w[0]);
    joystick1 = 12'($urandom);
    joystick2 = 12'($urandom);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy got %b want 1", busy); end
    for (int i = 0; i < 24; i++) begin
      e = exp_q.pop_front();
      cap[i] = joy_data;
      checks++;
      if (joy_data !== e) begin errors++; $display("FAIL frame_bit%0d got %b want %b", i, joy_data, e); end
      exp_q.push_back((i < 23) ? w[i+1] : 1'b1);
      pulse_clk(HOLD);
    end
    e = exp_q.pop_front();
    checks++; if (joy_data !== e) begin errors++; $display("FAIL frame_tail got %b want %b", joy_data, e); end
    checks++; if (~cap !== {p2, p1}) begin errors++; $display("FAIL frame_loopback got %h want %h", ~cap, {p2, p1}); end
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL frame_done_cnt got %0d want %0d", done_cnt - d0, 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL frame_overrun got %b want 0", overrun); end
  endtask

  task automatic test_abort();
    logic [23:0] w;
    logic        e;
    int          d0;
    w = {~12'h00F, ~12'h0F0};
    d0 = done_cnt;
    load_pulse(12'h0F0, 12'h00F);
    exp_q.push_back(w[0]);
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (joy_data !== e) begin errors++; $display("FAIL abort_bit%0d got %b want %b", i, joy_data, e); end
      exp_q.push_back(w[i+1]);
      pulse_clk(HOLD);
    end
    e = exp_q.pop_front();
    checks++; if (joy_data !== e) begin errors++; $display("FAIL abort_bit10 got %b want %b", joy_data, e); end
    load_pulse(12'h801, 12'h000);
    checks++; if (joy_data !== 1'b0) begin errors++; $display("FAIL abort_restart got %b want 0", joy_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b want 1", busy); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_overrun();
    test_frame(12'h5A5, 12'h0C3);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(1'b1);
      pulse_clk(HOLD);
      checks++;
      if (joy_data !== exp_q.pop_front()) begin errors++; $display("FAIL overrun_bit%0d got %b want 1", 25 + k, joy_data); end
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set%0d got %b want 1", k, overrun); end
    end
    joy_load = 1'b0;
    cyc(LAT + 1);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", overrun); end
    joy_load = 1'b1;
    cyc(HOLD);
  endtask

  task automatic test_simul();
    int d0;
    load_pulse(12'h001, 12'h000);
    for (int i = 0; i < 23; i++) pulse_clk(HOLD);
    d0 = done_cnt;
    joy_load = 1'b0;
    joy_clk = 1'b1;
    cyc(HOLD);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL simul_no_done got %0d want 0", done_cnt - d0); end
    checks++; if (joy_data !== 1'b0) begin errors++; $display("FAIL simul_bit0 got %b want 0", joy_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy got %b want 0", busy); end
    joy_clk = 1'b0;
    cyc(HOLD);
    joy_load = 1'b1;
    cyc(HOLD);
    for (int i = 0; i < 23; i++) pulse_clk(HOLD);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL simul_count23 got %0d want 0", done_cnt - d0); end
    pulse_clk(HOLD);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL simul_count24 got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_glitch();
    logic [23:0] w;
    int          idx;
    w = {~12'h000, ~12'h005};
`ifdef JOY_DB15_TX_FILTER_EN
    idx = 0;
`else
    idx = 1;
`endif
    load_pulse(12'h005, 12'h000);
    exp_q.push_back(w[idx]);
    pulse_clk(2);
    checks++;
    if (joy_data !== exp_q.pop_front()) begin errors++; $display("FAIL glitch_2clk got %b want %b", joy_data, w[idx]); end
    exp_q.push_back(w[idx+1]);
    pulse_clk(6);
    checks++;
    if (joy_data !== exp_q.pop_front()) begin errors++; $display("FAIL glitch_6clk got %b want %b", joy_data, w[idx+1]); end
  endtask

  task automatic test_reset_mid();
    int d0;
    load_pulse(12'hFFF, 12'hFFF);
    for (int i = 0; i < 5; i++) pulse_clk(HOLD);
    checks++; if (joy_data !== 1'b0) begin errors++; $display("FAIL rmid_pre got %b want 0", joy_data); end
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    checks++; if (joy_data !== 1'b1) begin errors++; $display("FAIL rmid_data got %b want 1", joy_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    cyc(2);
    reset_n = 1'b1;
    cyc(HOLD);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", done_cnt - d0); end
    checks++; if (joy_data !== 1'b1) begin errors++; $display("FAIL rmid_idle got %b want 1", joy_data); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_frame(12'h001, 12'h000);
    test_frame(12'hA5A, 12'h3C3);
    test_abort();
    test_frame(12'h801, 12'h000);
    test_overrun();
    test_simul();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
